csel_subtractor_32_seq: RTL and testbench

//  Sequential 32-bit carry-select subtractor: diff = minuend - subtrahend - bin.

---
 rtl/csel_pkg.sv | 19 +
 rtl/csel_slice.sv | 26 ++
 rtl/csel_subtractor_32_seq.sv | 147 ++++++++++++++
 tb/tb_csel_subtractor_32_seq.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/csel_pkg.sv
// Shared definitions for the sequential carry-select subtractor.
//   DATA_W         operand / result width
//   slice_w_legal  true for the slice widths the datapath supports
//   state_t        controller state encoding
package csel_pkg;

   localparam int DATA_W = 32;

   function automatic bit slice_w_legal(input int w);
      return (w == 4) || (w == 8) || (w == 16) || (w == 32);
   endfunction

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/csel_slice.sv
// One W-bit carry-select slice: sum/cout of a + b_inv + cin.
// Both carry-in cases are formed in parallel and cin only drives the final mux.
//   a      in   W  minuend slice
//   b_inv  in   W  inverted subtrahend slice
//   cin    in   1  carry in (inverted borrow)
//   sum    out  W  slice result
//   cout   out  1  carry out
module csel_slice #(
   parameter int W = 8
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b_inv,
   input  logic         cin,
   output logic [W-1:0] sum,
   output logic         cout
);

   logic [W:0] sum_c0;
   logic [W:0] sum_c1;

   assign sum_c0 = {1'b0, a} + {1'b0, b_inv};
   assign sum_c1 = {1'b0, a} + {1'b0, b_inv} + (W+1)'(1);

   assign {cout, sum} = cin ? sum_c1 : sum_c0;

endmodule

// File: rtl/csel_subtractor_32_seq.sv
// Sequential 32-bit subtractor: diff = minuend - subtrahend - bin, one
// SLICE_W-bit carry-select slice per clock, valid/ready on both sides.
//   clk         in   1   rising-edge clock
//   rst_n       in   1   asynchronous active-low reset
//   in_valid    in   1   operands valid
//   in_ready    out  1   operands can be accepted (IDLE)
//   minuend     in   32  A
//   subtrahend  in   32  B
//   bin         in   1   borrow in
//   out_valid   out  1   result valid (DONE)
//   out_ready   in   1   consumer accepts result
//   diff        out  32  A - B - bin modulo 2^32
//   bout        out  1   unsigned borrow out
//   ovf         out  1   signed overflow
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// RUN   | one slice per clock, low slice first
// DONE  | result presented until out_ready
module csel_subtractor_32_seq
   import csel_pkg::*;
#(
   parameter int SLICE_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] minuend,
   input  logic [DATA_W-1:0] subtrahend,
   input  logic              bin,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] diff,
   output logic              bout,
   output logic              ovf
);

   localparam int NUM_SLICES = DATA_W / SLICE_W;
   localparam int IDX_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

   if (!slice_w_legal(SLICE_W)) begin : g_bad_slice_w
      $error("csel_subtractor_32_seq: SLICE_W must be 4, 8, 16 or 32");
   end

   state_t            state_q, state_d;
   logic [DATA_W-1:0] a_q, b_inv_q, acc_q;
   logic [DATA_W-1:0] a_next, b_next, acc_next;
   logic [DATA_W-1:0] diff_q;
   logic [IDX_W-1:0]  idx_q;
   logic              carry_q, a_msb_q, b_msb_q, bout_q, ovf_q;
   logic [SLICE_W-1:0] slice_sum;
   logic              slice_cout;
   logic              accept, last;

   csel_slice #(.W(SLICE_W)) u_slice (
      .a     (a_q[SLICE_W-1:0]),
      .b_inv (b_inv_q[SLICE_W-1:0]),
      .cin   (carry_q),
      .sum   (slice_sum),
      .cout  (slice_cout)
   );

   // Operands shift down so the slice always sees the low bits; the working
   // result fills from the top so it is aligned after the last slice.
   if (NUM_SLICES > 1) begin : g_multi
      assign a_next   = {{SLICE_W{1'b0}}, a_q[DATA_W-1:SLICE_W]};
      assign b_next   = {{SLICE_W{1'b0}}, b_inv_q[DATA_W-1:SLICE_W]};
      assign acc_next = {slice_sum, acc_q[DATA_W-1:SLICE_W]};
   end else begin : g_single
      assign a_next   = a_q;
      assign b_next   = b_inv_q;
      assign acc_next = slice_sum;
   end

   assign accept = (state_q == IDLE) && in_valid;
   assign last   = (idx_q == LAST_IDX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_d = RUN;
         end
         RUN: begin
            if (last) state_d = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q     <= '0;
         b_inv_q <= '0;
         acc_q   <= '0;
         idx_q   <= '0;
         carry_q <= 1'b0;
         a_msb_q <= 1'b0;
         b_msb_q <= 1'b0;
         diff_q  <= '0;
         bout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else if (accept) begin
         a_q     <= minuend;
         b_inv_q <= ~subtrahend;
         acc_q   <= '0;
         idx_q   <= '0;
         carry_q <= ~bin;
         a_msb_q <= minuend[DATA_W-1];
         b_msb_q <= subtrahend[DATA_W-1];
      end else if (state_q == RUN) begin
         a_q     <= a_next;
         b_inv_q <= b_next;
         acc_q   <= acc_next;
         carry_q <= slice_cout;
         idx_q   <= idx_q + IDX_W'(1);
         // Published outputs only change when an operation completes.
         if (last) begin
            diff_q <= acc_next;
            bout_q <= ~slice_cout;
            ovf_q  <= (a_msb_q ^ b_msb_q) & (acc_next[DATA_W-1] ^ a_msb_q);
         end
      end
   end

   assign diff = diff_q;
   assign bout = bout_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_csel_subtractor_32_seq.sv
module tb_csel_subtractor_32_seq;

   logic        clk;
   logic        rst_n;
   logic        in_valid   [3];
   logic        in_ready   [3];
   logic [31:0] minuend    [3];
   logic [31:0] subtrahend [3];
   logic        bin        [3];
   logic        out_valid  [3];
   logic        out_ready  [3];
   logic [31:0] diff       [3];
   logic        bout       [3];
   logic        ovf        [3];

   int n_vec = 0;
   int n_err = 0;
   int nsl [3] = '{4, 8, 1};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   csel_subtractor_32_seq #(.SLICE_W(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .minuend(minuend[0]), .subtrahend(subtrahend[0]), .bin(bin[0]),
      .out_valid(out_valid[0]), .out_ready(out_ready[0]),
      .diff(diff[0]), .bout(bout[0]), .ovf(ovf[0]));

   csel_subtractor_32_seq #(.SLICE_W(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .minuend(minuend[1]), .subtrahend(subtrahend[1]), .bin(bin[1]),
      .out_valid(out_valid[1]), .out_ready(out_ready[1]),
      .diff(diff[1]), .bout(bout[1]), .ovf(ovf[1]));

   csel_subtractor_32_seq #(.SLICE_W(32)) u_dut32 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
      .minuend(minuend[2]), .subtrahend(subtrahend[2]), .bin(bin[2]),
      .out_valid(out_valid[2]), .out_ready(out_ready[2]),
      .diff(diff[2]), .bout(bout[2]), .ovf(ovf[2]));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wait_done(input int u, output int cnt);
      cnt = 0;
      while (!out_valid[u] && cnt < 100) begin
         @(posedge clk);
         cnt++;
         @(negedge clk);
      end
   endtask

   task automatic run_op(input int u, input logic [31:0] a, input logic [31:0] b,
                         input logic bi, input logic [31:0] exp_d,
                         input logic exp_bo, input logic exp_ov);
      int cnt;
      @(negedge clk);
      chk($sformatf("u%0d in_ready idle", u), 32'(in_ready[u]), 32'd1);
      minuend[u]    = a;
      subtrahend[u] = b;
      bin[u]        = bi;
      in_valid[u]   = 1'b1;
      out_ready[u]  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid[u]   = 1'b0;
      minuend[u]    = ~a;
      subtrahend[u] = a;
      bin[u]        = ~bi;
      wait_done(u, cnt);
      chk($sformatf("u%0d latency", u), 32'(cnt), 32'(nsl[u]));
      chk($sformatf("u%0d diff %h-%h", u, a, b), diff[u], exp_d);
      chk($sformatf("u%0d bout", u), 32'(bout[u]), 32'(exp_bo));
      chk($sformatf("u%0d ovf", u), 32'(ovf[u]), 32'(exp_ov));
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("u%0d out_valid drop", u), 32'(out_valid[u]), 32'd0);
      chk($sformatf("u%0d diff hold", u), diff[u], exp_d);
   endtask

   task automatic run_set(input int u);
      run_op(u, 32'h11abcdef, 32'h00aabbcc, 1'b0, 32'h11011223, 1'b0, 1'b0);
      run_op(u, 32'h05233458, 32'h04578213, 1'b0, 32'h00cbb245, 1'b0, 1'b0);
      run_op(u, 32'd25366408, 32'd40010303, 1'b0, 32'hff208d49, 1'b1, 1'b0);
      run_op(u, 32'h80000000, 32'h00000001, 1'b0, 32'h7fffffff, 1'b0, 1'b1);
      run_op(u, 32'h00000000, 32'h00000000, 1'b1, 32'hffffffff, 1'b1, 1'b0);
      run_op(u, 32'h00000100, 32'h00000000, 1'b1, 32'h000000ff, 1'b0, 1'b0);
   endtask

   initial begin
      int cnt;
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid[i] = 1'b0;  out_ready[i] = 1'b1;
         minuend[i] = '0;     subtrahend[i] = '0;  bin[i] = 1'b0;
      end
      #12;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("u%0d rst in_ready", i), 32'(in_ready[i]), 32'd1);
         chk($sformatf("u%0d rst out_valid", i), 32'(out_valid[i]), 32'd0);
         chk($sformatf("u%0d rst diff", i), diff[i], 32'd0);
         chk($sformatf("u%0d rst bout/ovf", i), {30'd0, bout[i], ovf[i]}, 32'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;

      for (int u = 0; u < 3; u++) run_set(u);

      // Backpressure on the 8-bit unit
      @(negedge clk);
      minuend[0] = 32'h05233458;  subtrahend[0] = 32'h04578213;  bin[0] = 1'b0;
      in_valid[0] = 1'b1;  out_ready[0] = 1'b0;
      @(posedge clk);
      @(negedge clk);
      in_valid[0] = 1'b0;
      wait_done(0, cnt);
      chk("bp latency", 32'(cnt), 32'd4);
      for (int i = 0; i < 5; i++) begin
         chk("bp out_valid", 32'(out_valid[0]), 32'd1);
         chk("bp in_ready", 32'(in_ready[0]), 32'd0);
         chk("bp diff stable", diff[0], 32'h00cbb245);
         if (i == 1) begin
            minuend[0] = 32'h12345678;  subtrahend[0] = 32'h00000001;
            in_valid[0] = 1'b1;
         end
         @(posedge clk);
         @(negedge clk);
      end
      in_valid[0] = 1'b0;
      out_ready[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("bp release out_valid", 32'(out_valid[0]), 32'd0);
      chk("bp release in_ready", 32'(in_ready[0]), 32'd1);
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         @(negedge clk);
      end
      chk("bp no queued op", 32'(out_valid[0]), 32'd0);
      chk("bp diff kept", diff[0], 32'h00cbb245);

      // Reset after two slices of an operation
      @(negedge clk);
      minuend[0] = 32'h11abcdef;  subtrahend[0] = 32'h00aabbcc;  bin[0] = 1'b0;
      in_valid[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid[0] = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrun rst out_valid", 32'(out_valid[0]), 32'd0);
      chk("midrun rst in_ready", 32'(in_ready[0]), 32'd1);
      chk("midrun rst diff", diff[0], 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op(0, 32'h11abcdef, 32'h00aabbcc, 1'b0, 32'h11011223, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
